snake_dir_ctrl: RTL and testbench

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Turns four raw pushbuttons into a committed snake direction and paces
//   movement steps for the drawing FSM with a request/acknowledge handshake.
//
//   Parameters
//     DB_CYCLES   cycles a synchronized key must differ from its debounced
//                 value before the change is accepted
//     STEP_PERIOD cycles between movement steps while enabled
//
//   Ports
//     Clock       single rising-edge clock
//     Resetn      asynchronous active-low reset
//     KEY[3:0]    raw active-low buttons: 0 right, 1 down, 2 up, 3 left
//     enable      game running; lets the step timer advance
//     step_ack    drawing FSM has consumed the pending step
//     step_req    high while a step is outstanding
//     step_dir    committed direction: 00 right, 01 down, 10 up, 11 left
//     rev_blocked one-cycle pulse when a 180-degree turn request is dropped
module snake_dir_ctrl #(
  parameter int DB_CYCLES   = 500000,
  parameter int STEP_PERIOD = 1048576
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] KEY,
  input  logic       enable,
  input  logic       step_ack,
  output logic       step_req,
  output logic [1:0] step_dir,
  output logic       rev_blocked
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int ST_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_PERIOD - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  logic [3:0]           key_meta_r;
  logic [3:0]           key_sync_r;
  logic [3:0]           db_key_r;
  logic [3:0][DB_W-1:0] db_cnt_r;
  logic [3:0]           press_s;
  logic                 press_any_s;
  logic [1:0]           req_dir_s;
  logic                 rev_s;
  logic [1:0]           pending_r;
  logic                 rev_blocked_r;
  state_t               state_r;
  state_t               state_nxt_s;
  logic [ST_W-1:0]      timer_r;
  logic [ST_W-1:0]      timer_nxt_s;
  logic                 step_req_nxt_s;
  logic                 commit_s;
  logic                 step_req_r;
  logic [1:0]           step_dir_r;

  // Two-flop synchronizer; released (1) is the reset value.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_meta_r <= 4'b1111;
      key_sync_r <= 4'b1111;
    end else begin
      key_meta_r <= KEY;
      key_sync_r <= key_meta_r;
    end
  end

  // Per-key debounce: count while the synchronized value disagrees, accept on the last count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      db_key_r <= 4'b1111;
      db_cnt_r <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_sync_r[i] != db_key_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_key_r[i] <= key_sync_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Press event fires on the edge where the debounced value drops 1->0.
  always_comb begin
    press_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      press_s[i] = db_key_r[i] & ~key_sync_r[i] & (db_cnt_r[i] == DB_LAST);
    end
  end

  // Fixed-priority pick of the winning press and reversal check against the committed direction.
  always_comb begin
    press_any_s = |press_s;
    if (press_s[0]) begin
      req_dir_s = 2'b00;
    end else if (press_s[1]) begin
      req_dir_s = 2'b01;
    end else if (press_s[2]) begin
      req_dir_s = 2'b10;
    end else if (press_s[3]) begin
      req_dir_s = 2'b11;
    end else begin
      req_dir_s = 2'b00;
    end
    rev_s = press_any_s && ((req_dir_s ^ step_dir_r) == 2'b11);
  end

  // Pending direction and reversal pulse; evaluated regardless of FSM state or enable.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pending_r     <= 2'b00;
      rev_blocked_r <= 1'b0;
    end else begin
      rev_blocked_r <= rev_s;
      if (press_any_s && !rev_s) begin
        pending_r <= req_dir_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; step_ack only matters in REQ.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && (timer_r == ST_LAST)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (step_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs and the step timer.
  always_comb begin
    step_req_nxt_s = (state_nxt_s == ST_REQ);
    commit_s       = (state_r == ST_IDLE) && (state_nxt_s == ST_REQ);
    timer_nxt_s    = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          if (timer_r == ST_LAST) begin
            timer_nxt_s = '0;
          end else begin
            timer_nxt_s = timer_r + 1'b1;
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      ST_REQ:  timer_nxt_s = '0;
      default: timer_nxt_s = '0;
    endcase
  end

  // Registered outputs and timer; direction only changes on the IDLE->REQ edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_req_r <= 1'b0;
      step_dir_r <= 2'b00;
      timer_r    <= '0;
    end else begin
      step_req_r <= step_req_nxt_s;
      timer_r    <= timer_nxt_s;
      if (commit_s) begin
        step_dir_r <= pending_r;
      end
    end
  end

  assign step_req    = step_req_r;
  assign step_dir    = step_dir_r;
  assign rev_blocked = rev_blocked_r;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DB_CYCLES=4, STEP_PERIOD=8.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
module tb_snake_dir_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] KEY;
  logic       enable;
  logic       step_ack;
  logic       step_req;
  logic [1:0] step_dir;
  logic       rev_blocked;

  int n_vec   = 0;
  int n_err   = 0;
  int rev_cnt = 0;

  snake_dir_ctrl #(
    .DB_CYCLES   (4),
    .STEP_PERIOD (8)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .KEY         (KEY),
    .enable      (enable),
    .step_ack    (step_ack),
    .step_req    (step_req),
    .step_dir    (step_dir),
    .rev_blocked (rev_blocked)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (rev_blocked === 1'b1) rev_cnt++;
  endtask

  // One full step period starting right after an ack (timer at 0):
  // KEY=k0, switched to k1 after step chg_at (9 = after the ack cycle).
  task automatic period(input string tag, input logic [3:0] k0, input int chg_at,
                        input logic [3:0] k1, input logic [1:0] exp_dir);
    KEY = k0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == chg_at) KEY = k1;
      if (i == 7) chk({tag, "_early"}, 32'(step_req), 32'd0);
    end
    chk({tag, "_req"}, 32'(step_req), 32'd1);
    chk({tag, "_dir"}, 32'(step_dir), 32'(exp_dir));
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    if (chg_at == 9) KEY = k1;
    chk({tag, "_ack"}, 32'(step_req), 32'd0);
  endtask

  initial begin
    Resetn   = 1'b0;
    KEY      = 4'b1111;
    enable   = 1'b0;
    step_ack = 1'b0;
    #2;
    chk("rst_req", 32'(step_req), 32'd0);
    chk("rst_dir", 32'(step_dir), 32'd0);
    chk("rst_rb",  32'(rev_blocked), 32'd0);
    step();
    step();
    chk("rst_hold_req", 32'(step_req), 32'd0);
    Resetn = 1'b1;
    enable = 1'b1;

    // Idle keys: first request 8 cycles after enable, then every 8 after ack.
    period("first", 4'b1111, 1, 4'b1111, 2'b00);
    period("second", 4'b1111, 1, 4'b1111, 2'b00);

    // Down for only 2 cycles is a bounce.
    rev_cnt = 0;
    period("short", 4'b1101, 2, 4'b1111, 2'b00);
    chk("short_rb", 32'(rev_cnt), 32'd0);

    // Left against committed right, held 10 cycles: one block pulse.
    rev_cnt = 0;
    period("rev_a", 4'b0111, 9, 4'b0111, 2'b00);
    period("rev_b", 4'b0111, 1, 4'b1111, 2'b00);
    chk("rev_pulses", 32'(rev_cnt), 32'd1);

    // Down held 10 cycles commits at the next step.
    period("down_a", 4'b1101, 9, 4'b1101, 2'b01);
    period("down_b", 4'b1101, 1, 4'b1111, 2'b01);

    // Right and up together from down: right wins.
    rev_cnt = 0;
    period("pri_a", 4'b1010, 9, 4'b1010, 2'b00);
    period("pri_b", 4'b1010, 1, 4'b1111, 2'b00);
    chk("pri_rb", 32'(rev_cnt), 32'd0);

    // enable low freezes the timer; ack in IDLE is ignored.
    repeat (4) step();
    chk("en_mid_req", 32'(step_req), 32'd0);
    enable   = 1'b0;
    step_ack = 1'b1;
    repeat (5) step();
    step_ack = 1'b0;
    chk("en_off_req", 32'(step_req), 32'd0);
    chk("en_off_timer", 32'(dut.timer_r), 32'd4);
    enable = 1'b1;
    repeat (3) step();
    chk("en_resume_early", 32'(step_req), 32'd0);
    step();
    chk("en_resume_req", 32'(step_req), 32'd1);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("en_ack", 32'(step_req), 32'd0);

    // Up, then left one cycle later: left is blocked against committed right.
    rev_cnt = 0;
    period("seq_a", 4'b1011, 1, 4'b0011, 2'b10);
    chk("seq_rb", 32'(rev_cnt), 32'd1);
    period("seq_b", 4'b0011, 1, 4'b1111, 2'b10);

    // Stall: no ack for 20 cycles, enable dropped halfway.
    repeat (7) step();
    chk("stall_early", 32'(step_req), 32'd0);
    step();
    chk("stall_req", 32'(step_req), 32'd1);
    repeat (10) step();
    enable = 1'b0;
    repeat (10) step();
    chk("stall_hold_req", 32'(step_req), 32'd1);
    chk("stall_hold_dir", 32'(step_dir), 32'd2);
    chk("stall_timer", 32'(dut.timer_r), 32'd0);
    enable   = 1'b1;
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("stall_ack", 32'(step_req), 32'd0);
    period("post_stall", 4'b1111, 1, 4'b1111, 2'b10);

    // Reset mid-REQ drops the request without a clock edge.
    repeat (8) step();
    chk("prerst_req", 32'(step_req), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_rst_req", 32'(step_req), 32'd0);
    chk("async_rst_dir", 32'(step_dir), 32'd0);
    chk("async_rst_rb",  32'(rev_blocked), 32'd0);
    step();
    Resetn = 1'b1;
    period("post_rst", 4'b1111, 1, 4'b1111, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
